zero_bist: RTL and testbench

ZERO_BIST -- requirements
Module: zero_bist

---
 rtl/zero_bist_if.sv | 19 +
 rtl/zero_bist.sv | 100 ++++++++++
 tb/tb_zero_bist.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/zero_bist_if.sv
// zero_bist_if: stimulus/response and status bundle between the BIST engine and its environment
interface zero_bist_if;
    logic       start;
    logic       is_zero;
    logic [7:0] n;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_count;
    logic [3:0] fail_index;
    modport master (
        input  start, is_zero,
        output n, busy, done, pass, fail_count, fail_index
    );
    modport slave (
        output start, is_zero,
        input  n, busy, done, pass, fail_count, fail_index
    );
endinterface

// File: rtl/zero_bist.sv
// zero_bist: walks a 13-entry vector table into a zero detector and scores its is_zero answers
module zero_bist #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       reset,
    zero_bist_if.master bus
);
    typedef enum logic [2:0] {IDLE, APPLY, WAIT, CHECK, DONE} state_t;
    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] fail_count_q, fail_count_d;
    logic [3:0] fail_index_q, fail_index_d;
    logic       pass_q, pass_d;
    logic [7:0] n_q, n_d;
    logic [7:0] vec;
    logic       exp_zero;
    logic       mismatch;
    // idx 0..7 walking one, then 0x00, 0xAA, 0x55, 0xFF, 0x00
    always_comb begin
        vec      = idx_q < 4'd8   ? 8'h01 << idx_q[2:0] :
                   idx_q == 4'd9  ? 8'hAA :
                   idx_q == 4'd10 ? 8'h55 :
                   idx_q == 4'd11 ? 8'hFF : 8'h00;
        exp_zero = idx_q == 4'd8 || idx_q == 4'd12;
        mismatch = bus.is_zero != exp_zero;
    end
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        n_d          = n_q;
        fail_count_d = fail_count_q;
        fail_index_d = fail_index_q;
        pass_d       = pass_q;
        case (state_q)
            IDLE: begin
                n_d = 8'h00;
                if (bus.start) begin
                    state_d      = APPLY;
                    idx_d        = 4'd0;
                    fail_count_d = 4'd0;
                    fail_index_d = 4'hF;
                    pass_d       = 1'b0;
                end
            end
            APPLY: begin
                n_d     = vec;
                cnt_d   = 4'(SETTLE - 1);
                state_d = WAIT;
            end
            WAIT: begin
                state_d = cnt_q == 4'd0 ? CHECK : WAIT;
                cnt_d   = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
            end
            CHECK: begin
                if (mismatch) begin
                    fail_count_d = fail_count_q == 4'd15 ? 4'd15 : fail_count_q + 4'd1;
                    fail_index_d = fail_index_q == 4'hF ? idx_q : fail_index_q;
                end
                if (idx_q == 4'd12) begin
                    state_d = DONE;
                    n_d     = 8'h00;
                    pass_d  = fail_count_d == 4'd0;
                end else begin
                    state_d = APPLY;
                    idx_d   = idx_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= 4'd0;
            cnt_q        <= 4'd0;
            n_q          <= 8'h00;
            fail_count_q <= 4'd0;
            fail_index_q <= 4'hF;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            n_q          <= n_d;
            fail_count_q <= fail_count_d;
            fail_index_q <= fail_index_d;
            pass_q       <= pass_d;
        end
    end
    assign bus.n          = n_q;
    assign bus.busy       = state_q == APPLY || state_q == WAIT || state_q == CHECK;
    assign bus.done       = state_q == DONE;
    assign bus.pass       = pass_q;
    assign bus.fail_count = fail_count_q;
    assign bus.fail_index = fail_index_q;
endmodule

// File: tb/tb_zero_bist.sv
// tb_zero_bist: randomized detector responses on two SETTLE variants, scored against a table-based model
module tb_zero_bist;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic is_zero = 1'b0;
    logic sel = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [7:0] vec [13] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                             8'h00, 8'hAA, 8'h55, 8'hFF, 8'h00};
    zero_bist_if ia();
    zero_bist_if ib();
    zero_bist #(.SETTLE(2)) dut_a (.clk(clk), .reset(reset), .bus(ia.master));
    zero_bist #(.SETTLE(1)) dut_b (.clk(clk), .reset(reset), .bus(ib.master));
    assign ia.start   = !sel && start;
    assign ia.is_zero = !sel && is_zero;
    assign ib.start   = sel && start;
    assign ib.is_zero = sel && is_zero;
    logic [7:0] o_n;
    logic       o_busy, o_done, o_pass;
    logic [3:0] o_fc, o_fi;
    assign o_n    = sel ? ib.n : ia.n;
    assign o_busy = sel ? ib.busy : ia.busy;
    assign o_done = sel ? ib.done : ia.done;
    assign o_pass = sel ? ib.pass : ia.pass;
    assign o_fc   = sel ? ib.fail_count : ia.fail_count;
    assign o_fi   = sel ? ib.fail_index : ia.fail_index;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode: 0 ideal, 1 stuck at 0, 2 stuck at 1, 3 random answers
    task automatic run(input logic s, input int mode, input int restart_at, input int abort_at);
        int   p, l, k, ph, fc, fi;
        logic r [13];
        bit   ab;
        sel = s;
        p = (s ? 1 : 2) + 2;
        l = 13 * p;
        fc = 0;
        fi = 15;
        ab = 0;
        for (int i = 0; i < 13; i++) begin
            if (mode == 0) r[i] = vec[i] == 8'h00;
            else if (mode == 1) r[i] = 1'b0;
            else if (mode == 2) r[i] = 1'b1;
            else r[i] = 1'($urandom_range(0, 1));
            if (r[i] != (vec[i] == 8'h00)) begin
                if (fi == 15) fi = i;
                if (fc < 15) fc++;
            end
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int t = 0; t <= l; t++) begin
            @(negedge clk);
            k = t / p;
            ph = t % p;
            start = (t == restart_at);
            if (t < l) begin
                is_zero = r[k];
                chk("busy_run", 8'(o_busy), 8'd1);
                chk("done_run", 8'(o_done), 8'd0);
                if (ph > 0) chk("n_vec", o_n, vec[k]);
                if (t == 0) begin
                    chk("fc_clear", 8'(o_fc), 8'd0);
                    chk("fi_clear", 8'(o_fi), 8'hF);
                    chk("pass_clear", 8'(o_pass), 8'd0);
                end
            end else begin
                chk("done_pulse", 8'(o_done), 8'd1);
                chk("busy_done", 8'(o_busy), 8'd0);
                chk("n_done", o_n, 8'h00);
                chk("pass_done", 8'(o_pass), 8'(fc == 0));
                chk("fc_done", 8'(o_fc), 8'(fc));
                chk("fi_done", 8'(o_fi), 8'(fi));
            end
            if (t == abort_at) begin
                reset = 1'b1;
                @(posedge clk);
                @(negedge clk);
                reset = 1'b0;
                chk("n_abort", o_n, 8'h00);
                chk("busy_abort", 8'(o_busy), 8'd0);
                chk("done_abort", 8'(o_done), 8'd0);
                chk("fc_abort", 8'(o_fc), 8'd0);
                chk("fi_abort", 8'(o_fi), 8'hF);
                for (int j = 0; j < 3 * l; j++) begin
                    @(negedge clk);
                    chk("no_done_abort", 8'(o_done), 8'd0);
                end
                ab = 1;
                break;
            end
        end
        if (!ab) begin
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                chk("done_once", 8'(o_done), 8'd0);
                chk("busy_idle", 8'(o_busy), 8'd0);
                chk("n_idle", o_n, 8'h00);
                chk("pass_hold", 8'(o_pass), 8'(fc == 0));
                chk("fc_hold", 8'(o_fc), 8'(fc));
                chk("fi_hold", 8'(o_fi), 8'(fi));
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            chk("rst_n", o_n, 8'h00);
            chk("rst_busy", 8'(o_busy), 8'd0);
            chk("rst_done", 8'(o_done), 8'd0);
            chk("rst_pass", 8'(o_pass), 8'd0);
            chk("rst_fc", 8'(o_fc), 8'd0);
            chk("rst_fi", 8'(o_fi), 8'hF);
        end
        sel = 1'b0;
        reset = 1'b0;
        run(1'b0, 0, -1, -1);
        run(1'b0, 1, -1, -1);
        run(1'b0, 2, -1, -1);
        run(1'b0, 0, 4 * 4 + 1, -1);
        run(1'b0, 3, -1, -1);
        run(1'b0, 3, 7 * 4 + 2, -1);
        run(1'b0, 2, -1, 5 * 4 + 1);
        run(1'b0, 0, -1, -1);
        run(1'b1, 0, -1, -1);
        run(1'b1, 3, -1, -1);
        run(1'b1, 1, -1, -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
